// File: rtl/mont_mult_arbiter.sv
// mont_mult_arbiter: round-robin sharing of one Montgomery multiplier between two requesters.
// Latches the winner's operands, pulses mult_start, waits for mult_done and returns the result.
module mont_mult_arbiter #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid0,
  input  logic         req_valid1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_m0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [W-1:0] req_m1,
  output logic         req_ack0,
  output logic         req_ack1,
  output logic         resp_done0,
  output logic         resp_done1,
  output logic [W-1:0] resp_result0,
  output logic [W-1:0] resp_result1,
  output logic         mult_start,
  output logic [W-1:0] mult_a,
  output logic [W-1:0] mult_b,
  output logic [W-1:0] mult_m,
  input  logic [W-1:0] mult_result,
  input  logic         mult_done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state;
  logic gnt, last, any, pick;
  // A tie goes to whoever did not win last time; otherwise the lone requester wins.
  always_comb begin
    any  = req_valid0 | req_valid1;
    pick = (req_valid0 & req_valid1) ? ~last : req_valid1;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      last         <= 1'b1;
      req_ack0     <= 1'b0;
      req_ack1     <= 1'b0;
      resp_done0   <= 1'b0;
      resp_done1   <= 1'b0;
      mult_start   <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      mult_m       <= '0;
      resp_result0 <= '0;
      resp_result1 <= '0;
    end else begin
      req_ack0   <= 1'b0;
      req_ack1   <= 1'b0;
      resp_done0 <= 1'b0;
      resp_done1 <= 1'b0;
      mult_start <= 1'b0;
      case (state)
        IDLE: if (any) begin
          gnt        <= pick;
          last       <= pick;
          mult_a     <= pick ? req_a1 : req_a0;
          mult_b     <= pick ? req_b1 : req_b0;
          mult_m     <= pick ? req_m1 : req_m0;
          req_ack0   <= ~pick;
          req_ack1   <= pick;
          mult_start <= 1'b1;
          state      <= START;
        end
        START: state <= WAIT;
        WAIT: if (mult_done) begin
          if (gnt) resp_result1 <= mult_result;
          else     resp_result0 <= mult_result;
          resp_done0 <= ~gnt;
          resp_done1 <= gnt;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mult_arbiter.sv
// tb_mont_mult_arbiter: randomized scenarios against a round-robin reference model
// with a behavioural multiplier that answers from the arbiter's operand bus.
module tb_mont_mult_arbiter;
  localparam int W = 32;
  logic clk = 0, reset = 1;
  logic [1:0] v = '0, ack, rd;
  logic [W-1:0] ra [2], rb [2], rm [2], rr [2];
  logic mult_start, mult_done = 0, busy;
  logic [W-1:0] mult_a, mult_b, mult_m, mult_result = '0;
  logic [W-1:0] exp_res [2];
  int last_ref;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mont_mult_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(v[0]), .req_valid1(v[1]),
    .req_a0(ra[0]), .req_b0(rb[0]), .req_m0(rm[0]),
    .req_a1(ra[1]), .req_b1(rb[1]), .req_m1(rm[1]),
    .req_ack0(ack[0]), .req_ack1(ack[1]),
    .resp_done0(rd[0]), .resp_done1(rd[1]),
    .resp_result0(rr[0]), .resp_result1(rr[1]),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_m(mult_m),
    .mult_result(mult_result), .mult_done(mult_done), .busy(busy)
  );

  function automatic logic [W-1:0] mm(input logic [W-1:0] a, b, m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, m});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomize_ops(input int k);
    ra[k] = $urandom;
    rb[k] = $urandom;
    rm[k] = $urandom | 32'h1;
  endtask

  task automatic apply_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    exp_res[0] = '0;
    exp_res[1] = '0;
    last_ref = 1;
    tick();
  endtask

  // One complete operation; who = granted requester, gap = ticks from call to ack.
  task automatic serve(input int lat, input bit refresh, input int late, input bit spur,
                       input bit use_fres, input logic [W-1:0] fres, output int who, output int gap);
    int n, ew, o;
    logic [W-1:0] oa, ob, om, expv;
    who = -1;
    gap = -1;
    ew = (v[0] && v[1]) ? 1 - last_ref : (v[1] ? 1 : 0);
    n = 0;
    while (ack == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n == 30) begin
      errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles, expected requester %0d", n, ew);
      return;
    end
    who = ack[1] ? 1 : 0;
    o = 1 - who;
    gap = n;
    checks++;
    if (ack !== (who ? 2'b10 : 2'b01) || who != ew) begin
      errors++;
      $display("FAIL grant_order: ack=%b expected requester %0d", ack, ew);
    end
    checks++;
    if (mult_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_with_ack: mult_start=%b busy=%b expected 1 1", mult_start, busy);
    end
    checks++;
    if (mult_a !== ra[who] || mult_b !== rb[who] || mult_m !== rm[who]) begin
      errors++;
      $display("FAIL operand_latch: a=%h b=%h m=%h expected %h %h %h",
               mult_a, mult_b, mult_m, ra[who], rb[who], rm[who]);
    end
    oa = ra[who];
    ob = rb[who];
    om = rm[who];
    expv = use_fres ? fres : mm(oa, ob, om);
    last_ref = who;
    if (refresh) randomize_ops(who);
    else v[who] = 1'b0;
    if (spur) begin
      mult_done = 1;
      mult_result = 'hFF;
    end
    tick();
    mult_done = 0;
    for (int i = 1; i <= lat; i++) begin
      checks++;
      if (ack !== 2'b00 || rd !== 2'b00 || mult_start !== 1'b0 || busy !== 1'b1 ||
          mult_a !== oa || mult_b !== ob || mult_m !== om || rr[0] !== exp_res[0] || rr[1] !== exp_res[1]) begin
        errors++;
        $display("FAIL wait_quiet: cyc %0d ack=%b done=%b start=%b busy=%b a=%h expected ack 00 done 00 start 0 busy 1 a=%h",
                 i, ack, rd, mult_start, busy, mult_a, oa);
      end
      if (late >= 0 && i == 2) v[late] = 1'b1;
      if (i == lat) begin
        mult_done = 1;
        mult_result = use_fres ? fres : mm(mult_a, mult_b, mult_m);
      end
      tick();
    end
    mult_done = 0;
    checks++;
    if (rd[who] !== 1'b1 || rd[o] !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resp_done: done=%b busy=%b expected requester %0d only, busy 1", rd, busy, who);
    end
    checks++;
    if (rr[who] !== expv || rr[o] !== exp_res[o]) begin
      errors++;
      $display("FAIL resp_result: own=%h other=%h expected %h %h", rr[who], rr[o], expv, exp_res[o]);
    end
    exp_res[who] = expv;
    tick();
    checks++;
    if (rd !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: done=%b busy=%b expected 00 0", rd, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (ack !== 2'b00 || rd !== 2'b00 || mult_start !== 1'b0 || busy !== 1'b0 ||
        mult_a !== '0 || mult_b !== '0 || mult_m !== '0 || rr[0] !== '0 || rr[1] !== '0) begin
      errors++;
      $display("FAIL %s: ack=%b done=%b start=%b busy=%b a=%h b=%h m=%h r0=%h r1=%h expected all zero",
               tag, ack, rd, mult_start, busy, mult_a, mult_b, mult_m, rr[0], rr[1]);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single();
    int who, gap;
    apply_reset();
    ra[0] = 3;
    rb[0] = 5;
    rm[0] = 7;
    v[0] = 1;
    serve(10, 0, -1, 0, 1, 'h2A, who, gap);
    checks++;
    if (gap != 1 || rr[0] !== 'h2A || rr[1] !== '0) begin
      errors++;
      $display("FAIL single: gap=%0d r0=%h r1=%h expected 1 2a 0", gap, rr[0], rr[1]);
    end
  endtask

  task automatic test_tie();
    int who, gap;
    apply_reset();
    randomize_ops(0);
    randomize_ops(1);
    v = 2'b11;
    serve($urandom_range(1, 8), 0, -1, 0, 0, '0, who, gap);
    serve($urandom_range(1, 8), 0, -1, 0, 0, '0, who, gap);
    checks++;
    if (who != 1 || gap != 1) begin
      errors++;
      $display("FAIL tie_second: who=%0d gap=%0d expected 1 1", who, gap);
    end
  endtask

  task automatic test_fairness();
    int who, gap;
    randomize_ops(0);
    randomize_ops(1);
    v = 2'b11;
    for (int k = 0; k < 6; k++) begin
      serve($urandom_range(1, 8), 1, -1, 0, 0, '0, who, gap);
      checks++;
      if (who != k % 2) begin
        errors++;
        $display("FAIL fairness: op %0d granted %0d expected %0d", k, who, k % 2);
      end
    end
    v = 2'b00;
  endtask

  task automatic test_late_arrival();
    int who, gap;
    tick();
    randomize_ops(0);
    randomize_ops(1);
    v[0] = 1;
    serve(6, 0, 1, 0, 0, '0, who, gap);
    serve($urandom_range(1, 8), 0, -1, 0, 0, '0, who, gap);
    checks++;
    if (who != 1) begin
      errors++;
      $display("FAIL late_arrival: granted %0d expected 1", who);
    end
  endtask

  task automatic test_spurious();
    int who, gap;
    mult_done = 1;
    mult_result = 'hFF;
    tick();
    mult_done = 0;
    tick();
    checks++;
    if (rd !== 2'b00 || busy !== 1'b0 || rr[0] !== exp_res[0] || rr[1] !== exp_res[1]) begin
      errors++;
      $display("FAIL spurious_idle: done=%b busy=%b r0=%h r1=%h expected 00 0 %h %h",
               rd, busy, rr[0], rr[1], exp_res[0], exp_res[1]);
    end
    randomize_ops(0);
    v[0] = 1;
    serve($urandom_range(1, 8), 0, -1, 1, 0, '0, who, gap);
  endtask

  task automatic test_reset_mid_wait();
    int who, gap, n;
    randomize_ops(0);
    v[0] = 1;
    n = 0;
    while (ack == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    v[0] = 0;
    repeat (4) tick();
    reset = 1;
    #1;
    check_reset_outputs("reset_async");
    tick();
    reset = 0;
    exp_res[0] = '0;
    exp_res[1] = '0;
    last_ref = 1;
    tick();
    mult_done = 1;
    mult_result = $urandom;
    tick();
    mult_done = 0;
    check_reset_outputs("reset_mid_wait");
    tick();
    check_reset_outputs("done_after_reset");
    randomize_ops(1);
    v[1] = 1;
    serve($urandom_range(1, 8), 0, -1, 0, 0, '0, who, gap);
    checks++;
    if (who != 1) begin
      errors++;
      $display("FAIL after_reset: granted %0d expected 1", who);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ra[k] = '0;
      rb[k] = '0;
      rm[k] = 1;
    end
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_late_arrival();
    test_spurious();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
